// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM encoding,
// id/counter widths and the vector address helper.
package int_ctrl_pkg;

   localparam int INT_VEC_STRIDE_LOG2 = 4;
   localparam int INT_ID_WIDTH        = 4;
   localparam int INT_CNT_WIDTH       = 4;

   typedef enum logic [2:0] {
      INT_IDLE   = 3'd0,
      INT_HOLD   = 3'd1,
      INT_ENTER  = 3'd2,
      INT_ISR    = 3'd3,
      INT_RETURN = 3'd4
   } int_state_e;

   // Moore output bundle decoded from the FSM state.
   typedef struct packed {
      logic                    pause;
      logic                    flag;
      logic                    isr;
      logic [INT_ID_WIDTH-1:0] id;
      logic [31:0]             pc;
   } int_out_t;

   // Per-line vector; 32-bit add wraps silently.
   function automatic logic [31:0] vec_addr(input logic [31:0]             base,
                                            input logic [INT_ID_WIDTH-1:0] id);
      return base + (32'(id) << INT_VEC_STRIDE_LOG2);
   endfunction

endpackage

// File: rtl/int_ctrl_irq.sv
// Request front end: edge detect, sticky pending bits, enable mask and a
// lowest-index-wins priority encoder over the eligible set.
module irq_pending
   import int_ctrl_pkg::*;
#(
   parameter int NUM_IRQ = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NUM_IRQ-1:0]      irq_in,
   input  logic                    en_we,
   input  logic [NUM_IRQ-1:0]      en_wdata,
   input  logic                    clr_vld,
   input  logic [INT_ID_WIDTH-1:0] clr_id,
   output logic [NUM_IRQ-1:0]      en_mask,
   output logic                    eligible_any,
   output logic [INT_ID_WIDTH-1:0] winner_id
);

   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] pending_nxt;
   logic [NUM_IRQ-1:0] eligible;

   always_ff @(posedge clk) begin
      if (clr) begin
         irq_q   <= '0;
         en_mask <= '0;
         pending <= '0;
      end else begin
         irq_q   <= irq_in;
         pending <= pending_nxt;
         if (en_we)
            en_mask <= en_wdata;
      end
   end

   // A fresh edge on the serviced line during ENTER must not be lost: set wins.
   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
      logic line_set;
      logic line_clr;
      assign line_set       = irq_in[i] & ~irq_q[i];
      assign line_clr       = clr_vld && (clr_id == INT_ID_WIDTH'(i));
      assign pending_nxt[i] = line_set | (pending[i] & ~line_clr);
   end

   assign eligible     = pending & en_mask;
   assign eligible_any = |eligible;

   always_comb begin
      winner_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (eligible[i])
            winner_id = INT_ID_WIDTH'(i);
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt sequencer: pauses the pipeline for a fixed window, redirects to
// the line's vector, and on mret redirects back to the captured resume PC.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int          NUM_IRQ     = 4,
   parameter logic [31:0] VEC_BASE    = 32'h0000_1000,
   parameter int          HOLD_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NUM_IRQ-1:0]      irq_in,
   input  logic                    en_we,
   input  logic [NUM_IRQ-1:0]      en_wdata,
   input  logic                    branch,
   input  logic [31:0]             epc_in,
   input  logic                    mret,
   output logic                    int_set_pl_pause,
   output logic                    int_flag,
   output logic [31:0]             nextpc_int,
   output logic                    in_isr,
   output logic [INT_ID_WIDTH-1:0] irq_id,
   output logic [NUM_IRQ-1:0]      en_mask
);

   localparam logic [INT_CNT_WIDTH-1:0] CNT_LOAD = INT_CNT_WIDTH'(HOLD_CYCLES - 1);

   int_state_e              state;
   int_state_e              state_nxt;
   logic [INT_CNT_WIDTH-1:0] cnt;
   logic [31:0]             epc;
   logic [INT_ID_WIDTH-1:0] id_q;
   logic                    eligible_any;
   logic [INT_ID_WIDTH-1:0] winner_id;
   logic                    take;
   logic                    ent_clr;
   int_out_t                out;

   irq_pending #(.NUM_IRQ(NUM_IRQ)) u_pend (
      .clk          (clk),
      .clr          (clr),
      .irq_in       (irq_in),
      .en_we        (en_we),
      .en_wdata     (en_wdata),
      .clr_vld      (ent_clr),
      .clr_id       (id_q),
      .en_mask      (en_mask),
      .eligible_any (eligible_any),
      .winner_id    (winner_id)
   );

   // A resolving branch or mret in IDLE defers entry so its redirect wins.
   assign take    = (state == INT_IDLE) && eligible_any && !branch && !mret;
   assign ent_clr = (state == INT_ENTER);

   always_ff @(posedge clk) begin
      if (clr)
         state <= INT_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt  <= '0;
         epc  <= '0;
         id_q <= '0;
      end else if (take) begin
         cnt  <= CNT_LOAD;
         epc  <= epc_in;
         id_q <= winner_id;
      end else if (state == INT_HOLD && cnt != '0) begin
         cnt  <= cnt - INT_CNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INT_IDLE:   if (take) state_nxt = INT_HOLD;
         INT_HOLD:   if (cnt == '0) state_nxt = INT_ENTER;
         INT_ENTER:  state_nxt = INT_ISR;
         INT_ISR:    if (mret) state_nxt = INT_RETURN;
         INT_RETURN: state_nxt = INT_IDLE;
         default:    state_nxt = INT_IDLE;
      endcase
   end

   always_comb begin
      out = '0;
      case (state)
         INT_HOLD:   out.pause = 1'b1;
         INT_ENTER: begin
            out.flag = 1'b1;
            out.pc   = vec_addr(VEC_BASE, id_q);
         end
         INT_ISR: begin
            out.isr = 1'b1;
            out.id  = id_q;
         end
         INT_RETURN: begin
            out.flag = 1'b1;
            out.pc   = epc;
         end
         default: out = '0;
      endcase
   end

   assign int_set_pl_pause = out.pause;
   assign int_flag         = out.flag;
   assign nextpc_int       = out.pc;
   assign in_isr           = out.isr;
   assign irq_id           = out.id;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, hand-written corner sequences,
// and random traffic against an episode-timeline reference model.
module tb_int_ctrl;

   localparam int          N  = 4;
   localparam int          H  = 2;
   localparam logic [31:0] VB = 32'h0000_1000;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          en_we = 1'b0;
   logic          branch = 1'b0;
   logic          mret = 1'b0;
   logic [N-1:0]  irq_in = '0;
   logic [N-1:0]  en_wdata = '0;
   logic [31:0]   epc_in = '0;
   logic          int_set_pl_pause, int_flag, in_isr;
   logic [31:0]   nextpc_int;
   logic [3:0]    irq_id;
   logic [N-1:0]  en_mask;

   int checks = 0;
   int errors = 0;

   int_ctrl #(.NUM_IRQ(N), .VEC_BASE(VB), .HOLD_CYCLES(H)) dut (
      .clk(clk), .clr(clr), .irq_in(irq_in), .en_we(en_we), .en_wdata(en_wdata),
      .branch(branch), .epc_in(epc_in), .mret(mret),
      .int_set_pl_pause(int_set_pl_pause), .int_flag(int_flag), .nextpc_int(nextpc_int),
      .in_isr(in_isr), .irq_id(irq_id), .en_mask(en_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // Reference model: a handler episode is the cycle it began (ent) and the
   // cycle of its return (ret); the phase of any cycle is arithmetic on those.
   typedef enum {P_IDLE, P_HOLD, P_ENTER, P_ISR, P_RET} ph_e;
   int           cyc = 0;
   int           ent = -1;
   int           ret = -1;
   int           svc = 0;
   logic [N-1:0] m_pend = '0, m_mask = '0, m_prev = '0;
   logic [31:0]  m_epc = '0;

   function automatic ph_e phase(input int c);
      if (ret >= 0 && c >= ret) return P_RET;
      if (ent < 0)              return P_IDLE;
      if (c - ent < H)          return P_HOLD;
      if (c - ent == H)         return P_ENTER;
      return P_ISR;
   endfunction

   function automatic logic [63:0] pk(input logic pause, input logic flag, input logic isr,
                                      input logic [3:0] id, input logic [31:0] pc,
                                      input logic [N-1:0] mask);
      return {21'b0, mask, pause, flag, isr, id, pc};
   endfunction

   function automatic logic [63:0] model_out();
      ph_e         p;
      logic [31:0] pc;
      p  = phase(cyc);
      pc = (p == P_ENTER) ? VB + 32'(svc) * 32'd16 : (p == P_RET) ? m_epc : 32'd0;
      return pk(p == P_HOLD, p == P_ENTER || p == P_RET, p == P_ISR,
                (p == P_ISR) ? 4'(svc) : 4'd0, pc, m_mask);
   endfunction

   function automatic logic [63:0] dut_out();
      return pk(int_set_pl_pause, int_flag, in_isr, irq_id, nextpc_int, en_mask);
   endfunction

   task automatic model_edge();
      ph_e          ph;
      logic [N-1:0] elig, lsb;
      ph   = phase(cyc);
      elig = m_pend & m_mask;
      if (clr) begin
         m_pend = '0; m_mask = '0; m_prev = '0; m_epc = '0;
         svc = 0; ent = -1; ret = -1;
      end else begin
         if (ph == P_IDLE && elig != '0 && !branch && !mret) begin
            lsb   = elig & (~elig + 1'b1);
            svc   = $clog2(lsb);
            ent   = cyc + 1;
            m_epc = epc_in;
         end
         if (ph == P_ENTER) m_pend[svc] = 1'b0;
         m_pend = m_pend | (irq_in & ~m_prev);
         m_prev = irq_in;
         if (en_we) m_mask = en_wdata;
         if (ph == P_ISR && mret) ret = cyc + 1;
         if (ph == P_RET) begin ent = -1; ret = -1; end
      end
      cyc++;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("model", dut_out(), model_out());
   endtask

   task automatic quiet();
      clr = 1'b0; en_we = 1'b0; branch = 1'b0; mret = 1'b0;
   endtask

   task automatic do_reset();
      clr = 1'b1; irq_in = '0; step(); quiet();
   endtask

   task automatic write_mask(input logic [N-1:0] m);
      en_we = 1'b1; en_wdata = m; step(); en_we = 1'b0;
   endtask

   // Returns the number of steps taken until int_flag appeared.
   task automatic wait_flag(input string name, input int max, output int n);
      bit ok;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < max) begin
         step();
         n++;
         if (int_flag) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s timeout after %0d cycles, required int_flag=1", name, max);
      end
   endtask

   typedef struct {
      logic [N-1:0] irq; logic we; logic [N-1:0] wd; logic br; logic [31:0] epc;
      logic mr; logic cl;
      logic pause; logic flag; logic isr; logic [3:0] id; logic [31:0] pc;
   } vec_t;
   vec_t tbl[10];

   initial begin
      int   n;
      logic acc;
      int   b;

      // {irq, we, wd, br, epc, mret, clr,   pause, flag, isr, id, pc}
      tbl[0] = '{4'b0000, 0, 4'b0000, 0, 32'h0,  0, 1,  0, 0, 0, 4'd0, 32'h0};
      tbl[1] = '{4'b0000, 1, 4'b0010, 0, 32'h0,  0, 0,  0, 0, 0, 4'd0, 32'h0};
      tbl[2] = '{4'b0010, 0, 4'b0000, 0, 32'h40, 0, 0,  0, 0, 0, 4'd0, 32'h0};
      tbl[3] = '{4'b0010, 0, 4'b0000, 0, 32'h40, 0, 0,  1, 0, 0, 4'd0, 32'h0};
      tbl[4] = '{4'b0000, 0, 4'b0000, 0, 32'h99, 0, 0,  1, 0, 0, 4'd0, 32'h0};
      tbl[5] = '{4'b0000, 0, 4'b0000, 0, 32'h99, 0, 0,  0, 1, 0, 4'd0, 32'h1010};
      tbl[6] = '{4'b0000, 0, 4'b0000, 0, 32'h99, 0, 0,  0, 0, 1, 4'd1, 32'h0};
      tbl[7] = '{4'b0000, 0, 4'b0000, 0, 32'h99, 0, 0,  0, 0, 1, 4'd1, 32'h0};
      tbl[8] = '{4'b0000, 0, 4'b0000, 0, 32'h99, 1, 0,  0, 1, 0, 4'd0, 32'h40};
      tbl[9] = '{4'b0000, 0, 4'b0000, 0, 32'h99, 0, 0,  0, 0, 0, 4'd0, 32'h0};

      for (int r = 0; r < 10; r++) begin
         irq_in = tbl[r].irq; en_we = tbl[r].we; en_wdata = tbl[r].wd; branch = tbl[r].br;
         epc_in = tbl[r].epc; mret = tbl[r].mr; clr = tbl[r].cl;
         step();
         check($sformatf("tbl%0d", r),
               64'({int_set_pl_pause, int_flag, in_isr, irq_id, nextpc_int}),
               64'({tbl[r].pause, tbl[r].flag, tbl[r].isr, tbl[r].id, tbl[r].pc}));
      end
      quiet();
      check("reset_mask", 64'(en_mask), 64'(4'b0010));

      // Two lines at once: lowest first, the other follows after mret unprompted.
      do_reset();
      write_mask(4'b1111);
      epc_in = 32'h500;
      irq_in = 4'b1100;
      step();
      wait_flag("prio_first", 10, n);
      check("prio_latency", 64'(n), 64'(H + 1));
      check("prio_vec2", 64'(nextpc_int), 64'(32'h1020));
      step();
      check("prio_id2", 64'({in_isr, irq_id}), 64'({1'b1, 4'd2}));
      mret = 1'b1; step(); mret = 1'b0;
      check("prio_ret", 64'({int_flag, nextpc_int}), 64'({1'b1, 32'h500}));
      wait_flag("prio_second", 10, n);
      check("prio_reentry", 64'(n), 64'(H + 2));
      check("prio_vec3", 64'(nextpc_int), 64'(32'h1030));
      step();
      check("prio_id3", 64'({in_isr, irq_id}), 64'({1'b1, 4'd3}));
      mret = 1'b1; step(); mret = 1'b0; step();

      // Branch in IDLE defers entry; epc sampled on the actual entry edge.
      do_reset();
      write_mask(4'b0001);
      irq_in = 4'b0001; step();
      branch = 1'b1; epc_in = 32'h222;
      acc = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); acc |= int_set_pl_pause; end
      check("br_nohold", 64'(acc), 64'(1'b0));
      branch = 1'b0; epc_in = 32'h1234; step();
      check("br_hold", 64'(int_set_pl_pause), 64'(1'b1));
      epc_in = 32'h0;
      wait_flag("br_enter", 10, n);
      check("br_vec", 64'(nextpc_int), 64'(VB));
      step();
      mret = 1'b1; step(); mret = 1'b0;
      check("br_epc", 64'({int_flag, nextpc_int}), 64'({1'b1, 32'h1234}));
      step();

      // Masked request waits; enabling it enters HOLD two cycles after the write.
      do_reset();
      irq_in = 4'b0010; step();
      acc = 1'b0;
      for (int i = 0; i < 4; i++) begin step(); acc |= int_set_pl_pause; end
      check("mask_nohold", 64'(acc), 64'(1'b0));
      write_mask(4'b0010);
      check("mask_wr_cycle", 64'(int_set_pl_pause), 64'(1'b0));
      step();
      check("mask_hold", 64'(int_set_pl_pause), 64'(1'b1));

      // clr during HOLD: no redirect, pending gone.
      clr = 1'b1; irq_in = '0; step(); quiet();
      check("clr_hold_out", dut_out(), 64'(0));
      write_mask(4'b1111);
      acc = 1'b0;
      for (int i = 0; i < 6; i++) begin step(); acc |= int_flag | int_set_pl_pause; end
      check("clr_hold_nopend", 64'(acc), 64'(1'b0));

      // clr during ISR.
      irq_in = 4'b0001; step();
      wait_flag("clr_isr_enter", 10, n);
      step();
      check("clr_isr_in", 64'(in_isr), 64'(1'b1));
      clr = 1'b1; irq_in = '0; step(); quiet();
      check("clr_isr_out", dut_out(), 64'(0));
      acc = 1'b0;
      for (int i = 0; i < 4; i++) begin step(); acc |= int_flag; end
      check("clr_isr_noflag", 64'(acc), 64'(1'b0));

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, N - 1);
            irq_in[b] = ~irq_in[b];
         end
         en_we    = ($urandom_range(0, 15) == 0);
         en_wdata = N'($urandom);
         branch   = ($urandom_range(0, 3) == 0);
         epc_in   = $urandom;
         mret     = ($urandom_range(0, 5) == 0);
         clr      = ($urandom_range(0, 199) == 0);
         step();
      end
      quiet();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
